// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: round-robin scheduler for two word-stream requesters in front of a 16-bit SPI
// data path. Generates SSN/SCLK and runs the write/start/rx-ready/read handshake for each word.
module spi_xfer_sched #(
  parameter int unsigned DATA_SIZE  = 16,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned SSN_GAP    = 4,
  parameter int unsigned RX_TIMEOUT = 64,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  input  logic [1:0]  i_req,
  input  logic [1:0]  i_cpol,
  input  logic [1:0]  i_cpha,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_last,
  output logic [1:0]  o_gnt,
  output logic [1:0]  o_wack,
  output logic [15:0] o_rdata,
  output logic [1:0]  o_rvalid,
  output logic [1:0]  o_done,
  output logic [1:0]  o_err,
  output logic [15:0] o_dp_data,
  output logic        o_dp_wr,
  output logic        o_dp_rd,
  output logic        o_dp_csn,
  output logic        o_dp_start,
  input  logic        i_dp_tx_ready,
  input  logic        i_dp_rx_ready,
  input  logic [15:0] i_dp_rdata,
  output logic        o_cpol,
  output logic        o_cpha,
  output logic        o_sclk,
  output logic        o_ssn
);

  localparam int unsigned CntMaxA = (CLK_DIV > SSN_GAP) ? CLK_DIV : SSN_GAP;
  localparam int unsigned CntMax  = (RX_TIMEOUT > CntMaxA) ? RX_TIMEOUT : CntMaxA;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam int unsigned EdgeW   = $clog2(2 * DATA_SIZE + 1);

  localparam logic [CntW-1:0]  DivEnd   = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0]  GapEnd   = CntW'(SSN_GAP - 1);
  localparam logic [CntW-1:0]  RxEnd    = CntW'(RX_TIMEOUT - 1);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_SIZE - 1);
  localparam logic [3:0]       BurstEnd = 4'(MAX_BURST);

  typedef enum logic [2:0] {
    StIdle, StLoad, StStart, StSetup, StShift, StWaitRx, StRead, StDeassert
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [EdgeW-1:0] edge_q, edge_d;
  logic [3:0]       burst_q, burst_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic             rr_q, rr_d;

  logic [1:0]  gnt_q, gnt_d, wack_q, wack_d, rvalid_q, rvalid_d;
  logic [1:0]  done_q, done_d, err_q, err_d;
  logic [15:0] rdata_q, rdata_d, dp_data_q, dp_data_d;
  logic        dp_wr_q, dp_wr_d, dp_rd_q, dp_rd_d, dp_csn_q, dp_csn_d, dp_start_q, dp_start_d;
  logic        cpol_q, cpol_d, cpha_q, cpha_d, sclk_q, sclk_d, ssn_q, ssn_d;

  logic       pick;
  logic [3:0] burst_inc;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    burst_d    = burst_q;
    last_d     = last_q;
    sel_d      = sel_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    rdata_d    = rdata_q;
    dp_data_d  = dp_data_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    sclk_d     = sclk_q;
    ssn_d      = ssn_q;
    wack_d     = '0;
    rvalid_d   = '0;
    done_d     = '0;
    err_d      = '0;
    dp_wr_d    = 1'b0;
    dp_rd_d    = 1'b0;
    dp_start_d = 1'b0;
    dp_csn_d   = 1'b1;
    // With both requesting, the one not granted last wins.
    pick       = (i_req == 2'b11) ? ~rr_q : i_req[1];
    burst_inc  = (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;

    unique case (state_q)
      StIdle: begin
        if (|i_req) begin
          sel_d   = pick;
          rr_d    = pick;
          gnt_d   = pick ? 2'b10 : 2'b01;
          cpol_d  = i_cpol[pick];
          cpha_d  = i_cpha[pick];
          sclk_d  = i_cpol[pick];
          burst_d = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (i_dp_tx_ready) begin
          dp_wr_d   = 1'b1;
          dp_csn_d  = 1'b0;
          dp_data_d = sel_q ? i_wdata[31:16] : i_wdata[15:0];
          wack_d    = gnt_q;
          // The requester advances to its next word after wack, so keep this word's last flag.
          last_d    = i_last[sel_q];
          state_d   = StStart;
        end
      end
      StStart: begin
        dp_start_d = 1'b1;
        dp_csn_d   = 1'b0;
        ssn_d      = 1'b0;
        cnt_d      = '0;
        state_d    = StSetup;
      end
      StSetup: begin
        if (cnt_q == DivEnd) begin
          sclk_d  = ~sclk_q;
          edge_d  = EdgeW'(1);
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShift: begin
        if (cnt_q == DivEnd) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          cnt_d  = '0;
          if (edge_q == LastEdge) state_d = StWaitRx;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitRx: begin
        if (i_dp_rx_ready) begin
          dp_rd_d  = 1'b1;
          dp_csn_d = 1'b0;
          state_d  = StRead;
        end else if (cnt_q == RxEnd) begin
          err_d   = gnt_q;
          ssn_d   = 1'b1;
          cnt_d   = '0;
          state_d = StDeassert;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRead: begin
        rdata_d  = i_dp_rdata;
        rvalid_d = gnt_q;
        burst_d  = burst_inc;
        cnt_d    = '0;
        if (last_q) begin
          done_d  = gnt_q;
          ssn_d   = 1'b1;
          state_d = StDeassert;
        end else if (burst_inc >= BurstEnd) begin
          err_d   = gnt_q;
          ssn_d   = 1'b1;
          state_d = StDeassert;
        end else begin
          state_d = StLoad;
        end
      end
      StDeassert: begin
        ssn_d = 1'b1;
        if (cnt_q == GapEnd) begin
          gnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      edge_q     <= '0;
      burst_q    <= '0;
      last_q     <= 1'b0;
      sel_q      <= 1'b0;
      rr_q       <= 1'b1;
      gnt_q      <= '0;
      wack_q     <= '0;
      rvalid_q   <= '0;
      done_q     <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
      dp_data_q  <= '0;
      dp_wr_q    <= 1'b0;
      dp_rd_q    <= 1'b0;
      dp_csn_q   <= 1'b1;
      dp_start_q <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      sclk_q     <= 1'b0;
      ssn_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      burst_q    <= burst_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      wack_q     <= wack_d;
      rvalid_q   <= rvalid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      dp_data_q  <= dp_data_d;
      dp_wr_q    <= dp_wr_d;
      dp_rd_q    <= dp_rd_d;
      dp_csn_q   <= dp_csn_d;
      dp_start_q <= dp_start_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      sclk_q     <= sclk_d;
      ssn_q      <= ssn_d;
    end
  end

  assign o_gnt      = gnt_q;
  assign o_wack     = wack_q;
  assign o_rdata    = rdata_q;
  assign o_rvalid   = rvalid_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_dp_data  = dp_data_q;
  assign o_dp_wr    = dp_wr_q;
  assign o_dp_rd    = dp_rd_q;
  assign o_dp_csn   = dp_csn_q;
  assign o_dp_start = dp_start_q;
  assign o_cpol     = cpol_q;
  assign o_cpha     = cpha_q;
  assign o_sclk     = sclk_q;
  assign o_ssn      = ssn_q;

endmodule
